fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer and next-PC arbiter for the single-issue core. Owns the program counter.
//  Each cycle it picks the next PC from four sources: reset vector, trap vector, jump/branch
//  target, or sequential PC+4.
//  Issues one instruction-memory request at a time over a req/ready + rvalid handshake and
//  hands each fetched word to decode. Sits between the branch/trap logic and the imem port.
// PARAMETERS
//  XLEN          32            PC/address width
//  RESET_VECTOR  32'h0000_0000 PC loaded on reset
//  TRAP_VECTOR   32'h0000_0100 PC loaded on trap or misaligned jump target
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high; clears all state
//  stall        in   1     decode cannot accept; blocks issuing a new request
//  j_signal     in   1     jump/branch taken this cycle
//  jump         in   XLEN  jump/branch target, qualified by j_signal
//  trap         in   1     exception request; redirect to TRAP_VECTOR
//  halt         in   1     stop fetching (ebreak); sticky until reset
//  imem_req     out  1     request valid
//  imem_addr    out  XLEN  request address; always equals out
//  imem_ready   in   1     memory accepts request (sampled with imem_req)
//  imem_rvalid  in   1     response valid, one cycle per accepted request
//  imem_rdata   in   32    response instruction word
//  out          out  XLEN  current PC
//  instr_valid  out  1     one-cycle pulse: instr/instr_pc hold a new instruction
//  instr        out  32    fetched instruction; held between pulses
//  instr_pc     out  XLEN  PC of instr
//  misaligned   out  1     one-cycle pulse: jump target with [1:0] != 0 was converted to a trap
// BEHAVIOUR
//  Reset values: out = imem_addr = RESET_VECTOR; imem_req = 0; instr_valid = 0;
//   instr = 32'h0000_0013 (NOP); instr_pc = 0; misaligned = 0; kill = 0; state = BOOT.
//  FSM states:
//   BOOT   -> IDLE after 1 cycle. imem_req = 0.
//   IDLE   imem_req = 0. Goes to REQ when stall = 0 and no halt latched; goes to HALTED if halt
//          is latched.
//   REQ    imem_req = 1; imem_addr held stable until imem_ready. The request is never withdrawn,
//          even if stall rises. REQ -> RESP on the cycle imem_req && imem_ready.
//   RESP   imem_req = 0; waits for imem_rvalid. No timeout. On imem_rvalid -> IDLE, or -> HALTED
//          if halt is latched.
//   HALTED imem_req = 0; instr_valid = 0. Only reset exits this state.
//  Delivery: when imem_rvalid is sampled in RESP and kill = 0, the next cycle has
//   instr_valid = 1, instr = imem_rdata and instr_pc = the request address. In that case
//   out <= out + 4 (mod 2^XLEN, so 32'hFFFF_FFFC wraps to 0).
//   Minimum cadence is 3 cycles per instruction (IDLE, REQ, RESP).
//  Redirect priority within one cycle: reset > trap > j_signal > halt > stall.
//   trap: target = TRAP_VECTOR.
//   j_signal with jump[1:0] != 0: target = TRAP_VECTOR, misaligned pulses next cycle.
//   otherwise target = jump.
//  Redirect in BOOT or IDLE: out <= target on the next edge; no request is outstanding.
//  Redirect in REQ or RESP: target goes to a pending register and kill is set.
//   imem_addr is not disturbed. A later redirect overwrites pending (latest wins).
//   When imem_rvalid arrives with kill = 1: instr_valid stays 0, out <= pending, kill clears.
//  Redirect on the same edge as imem_rvalid in RESP: the response is killed and
//   out <= the new target.
//  halt is latched on any cycle. An outstanding transaction completes first; its response is
//   delivered unless killed. No new request is issued after halt is latched.
//  stall only gates IDLE -> REQ. instr/instr_pc hold while stalled.
//  Reset mid-transaction abandons the request. An imem_rvalid seen outside RESP is ignored.
// TESTING
//  1. Reset, then imem_ready=1, rvalid one cycle after acceptance -> addr 0,4,8;
//     instr_valid every 3 cycles; instr_pc matches.
//  2. imem_ready held 0 for 4 cycles with j_signal=1, jump=32'h40 during REQ -> imem_addr stays 0;
//     the response is killed; the next request is to 32'h40.
//  3. trap and j_signal (jump=32'h80) in the same IDLE cycle -> next out = 32'h100;
//     no request to 32'h80.
//  4. j_signal=1, jump=32'h42 -> misaligned pulse, next fetch from 32'h100.
//  5. out=32'hFFFF_FFFC, fetch delivered -> next imem_addr = 0.
//  6. stall=1 for 5 cycles in IDLE, then halt during RESP -> no req while stalled; the response
//     is delivered; then HALTED, imem_req=0 until reset.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch sequencer and next-PC arbiter. Owns the program
//                counter, issues one instruction-memory request at a time
//                over a req/ready + rvalid handshake, and hands each fetched
//                word to decode. Redirects (trap, jump/branch) and halt are
//                folded into the PC selection here.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            j_signal,
   input  logic [XLEN-1:0] jump,
   input  logic            trap,
   input  logic            halt,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] out,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            misaligned
);

   // Canonical NOP (addi x0, x0, 0) presented to decode before the first fetch.
   localparam logic [31:0]     c_nop  = 32'h0000_0013;
   localparam logic [XLEN-1:0] c_four = XLEN'(4);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_IDLE   = 3'd1,
      S_REQ    = 3'd2,
      S_RESP   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pending;
   logic            r_kill;
   logic            r_halt;
   logic            r_req;
   logic            r_instr_valid;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_instr_pc;
   logic            r_misaligned;

   logic            w_redirect;
   logic            w_jmp_mis;
   logic [XLEN-1:0] w_target;
   logic            w_halt;
   logic [XLEN-1:0] w_pc_inc;

   // Next-PC arbitration: trap beats jump; a misaligned jump target is
   // turned into a trap so decode never sees a half-word PC.
   always_comb begin
      w_redirect = trap | j_signal;
      w_jmp_mis  = j_signal & ~trap & (jump[1:0] != 2'b00);
      w_target   = (trap | w_jmp_mis) ? TRAP_VECTOR : jump;
      w_halt     = r_halt | halt;
      w_pc_inc   = r_pc + c_four;
   end

   // Fetch sequencer: state, PC, pending redirect, halt latch and all outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_VECTOR;
         r_pending     <= RESET_VECTOR;
         r_kill        <= 1'b0;
         r_halt        <= 1'b0;
         r_req         <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instr       <= c_nop;
         r_instr_pc    <= '0;
         r_misaligned  <= 1'b0;
      end else begin
         r_instr_valid <= 1'b0;
         r_misaligned  <= 1'b0;

         // halt is sticky; it only stops new requests from being issued
         if (halt) begin
            r_halt <= 1'b1;
         end

         // A misaligned jump is reported whenever a redirect is honoured,
         // which is every state except HALTED.
         if (r_state != S_HALTED) begin
            r_misaligned <= w_jmp_mis;
         end

         case (r_state)
            S_BOOT: begin
               r_req <= 1'b0;
               if (w_redirect) begin
                  r_pc <= w_target;
               end
               r_state <= S_IDLE;
            end

            S_IDLE: begin
               // Nothing outstanding, so a redirect can move the PC directly.
               // It takes this cycle; the request goes out next cycle.
               if (w_redirect) begin
                  r_pc <= w_target;
               end else if (w_halt) begin
                  r_state <= S_HALTED;
               end else if (!stall) begin
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end

            S_REQ: begin
               // The address must stay stable until accepted, so redirects
               // are parked and the in-flight response is marked for killing.
               if (w_redirect) begin
                  r_pending <= w_target;
                  r_kill    <= 1'b1;
               end
               if (imem_ready) begin
                  r_req   <= 1'b0;
                  r_state <= S_RESP;
               end
            end

            S_RESP: begin
               if (imem_rvalid) begin
                  if (w_redirect) begin
                     // Redirect coincides with the response: drop the word.
                     r_pc   <= w_target;
                     r_kill <= 1'b0;
                  end else if (r_kill) begin
                     r_pc   <= r_pending;
                     r_kill <= 1'b0;
                  end else begin
                     r_instr_valid <= 1'b1;
                     r_instr       <= imem_rdata;
                     r_instr_pc    <= r_pc;
                     r_pc          <= w_pc_inc;
                  end
                  r_state <= w_halt ? S_HALTED : S_IDLE;
               end else if (w_redirect) begin
                  r_pending <= w_target;
                  r_kill    <= 1'b1;
               end
            end

            S_HALTED: begin
               r_req <= 1'b0;
            end

            default: begin
               r_req   <= 1'b0;
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign out         = r_pc;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign misaligned  = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Scoreboard bench for fetch_ctrl. Stimulus pushes expected
//                request addresses and delivered instructions into queues;
//                a memory model/monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b1;
   logic        j_signal = 1'b0;
   logic [31:0] jump = 32'h0;
   logic        trap = 1'b0;
   logic        halt = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] out;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misaligned;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_req_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_ins_q[$];

   bit ready_en  = 1'b0;
   bit cad_en    = 1'b0;
   int cyc       = 0;
   int last_del  = -1;
   int mis_count = 0;

   fetch_ctrl #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0100)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .j_signal    (j_signal),
      .jump        (jump),
      .trap        (trap),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out         (out),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .misaligned  (misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model and monitor; runs on the falling edge, away from the DUT edge.
   initial begin : mem_model
      bit          acc;
      logic [31:0] acc_addr;
      acc         = 1'b0;
      acc_addr    = 32'h0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            acc         = 1'b0;
            imem_ready  = 1'b0;
            imem_rvalid = 1'b0;
         end else begin
            imem_rvalid = acc;
            imem_rdata  = acc ? memword(acc_addr) : 32'h0;
            if (instr_valid) begin
               if (exp_pc_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_delivery: got pc %h expected no delivery", instr_pc);
               end else begin
                  check("deliv_pc", instr_pc, exp_pc_q.pop_front());
                  check("deliv_instr", instr, exp_ins_q.pop_front());
               end
               if (cad_en && last_del >= 0) begin
                  check("cadence", 32'(cyc - last_del), 32'd3);
               end
               last_del = cyc;
            end
            if (misaligned) begin
               mis_count++;
            end
            imem_ready = ready_en;
            acc        = imem_req && imem_ready;
            if (acc) begin
               acc_addr = imem_addr;
               if (exp_req_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_request: got addr %h expected no request", imem_addr);
               end else begin
                  check("req_addr", imem_addr, exp_req_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      stall    = 1'b1;
      j_signal = 1'b0;
      trap     = 1'b0;
      halt     = 1'b0;
      jump     = 32'h0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rst_out"}, out, 32'h0);
      check({tag, "_rst_addr"}, imem_addr, 32'h0);
      check({tag, "_rst_req"}, {31'h0, imem_req}, 32'h0);
      check({tag, "_rst_valid"}, {31'h0, instr_valid}, 32'h0);
      check({tag, "_rst_instr"}, instr, 32'h0000_0013);
      check({tag, "_rst_pc"}, instr_pc, 32'h0);
      check({tag, "_rst_mis"}, {31'h0, misaligned}, 32'h0);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!instr_valid && n < 40);
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("FAIL %s: got instr_valid=0 expected 1 within %0d cycles", name, n);
      end
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!imem_req && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (!imem_req) begin
         errors++;
         $display("FAIL %s: got imem_req=0 expected 1 within %0d cycles", name, n);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] a);
      exp_req_q.push_back(a);
      exp_pc_q.push_back(a);
      exp_ins_q.push_back(memword(a));
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_req_q_left"}, 32'(exp_req_q.size()), 32'd0);
      check({tag, "_del_q_left"}, 32'(exp_pc_q.size()), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      // 1: sequential fetch 0,4,8 at one instruction per 3 cycles
      ready_en = 1'b1;
      do_reset();
      check_reset_vals("t1");
      tick();
      check("t1_boot_req", {31'h0, imem_req}, 32'h0);
      expect_fetch(32'h0);
      expect_fetch(32'h4);
      expect_fetch(32'h8);
      cad_en   = 1'b1;
      last_del = -1;
      stall    = 1'b0;
      wait_valid("t1_v0");
      wait_valid("t1_v1");
      wait_valid("t1_v2");
      stall = 1'b1;
      tick();
      cad_en = 1'b0;
      check("t1_out", out, 32'hC);
      check_drained("t1");

      // 2: jump while request is stalled by imem_ready=0
      ready_en = 1'b0;
      do_reset();
      check_reset_vals("t2");
      exp_req_q.push_back(32'h0);
      expect_fetch(32'h40);
      stall = 1'b0;
      wait_req("t2_req");
      j_signal = 1'b1;
      jump     = 32'h40;
      tick();
      j_signal = 1'b0;
      jump     = 32'h0;
      for (int i = 0; i < 3; i++) begin
         check("t2_addr_hold", imem_addr, 32'h0);
         check("t2_req_hold", {31'h0, imem_req}, 32'h1);
         tick();
      end
      ready_en = 1'b1;
      wait_valid("t2_v");
      stall = 1'b1;
      tick();
      check("t2_out", out, 32'h44);
      check_drained("t2");

      // 3: trap and aligned jump together in IDLE; trap wins
      do_reset();
      repeat (3) tick();
      trap     = 1'b1;
      j_signal = 1'b1;
      jump     = 32'h80;
      tick();
      trap     = 1'b0;
      j_signal = 1'b0;
      jump     = 32'h0;
      check("t3_out", out, 32'h100);
      check("t3_mis", {31'h0, misaligned}, 32'h0);
      expect_fetch(32'h100);
      stall = 1'b0;
      wait_valid("t3_v");
      stall = 1'b1;
      tick();
      check_drained("t3");

      // 4: misaligned jump becomes trap with a one-cycle pulse
      do_reset();
      repeat (3) tick();
      j_signal = 1'b1;
      jump     = 32'h42;
      tick();
      j_signal = 1'b0;
      jump     = 32'h0;
      check("t4_mis_pulse", {31'h0, misaligned}, 32'h1);
      check("t4_out", out, 32'h100);
      tick();
      check("t4_mis_clear", {31'h0, misaligned}, 32'h0);
      expect_fetch(32'h100);
      stall = 1'b0;
      wait_valid("t4_v");
      stall = 1'b1;
      tick();
      check_drained("t4");

      // 5: PC wraps from FFFF_FFFC to 0
      do_reset();
      repeat (3) tick();
      j_signal = 1'b1;
      jump     = 32'hFFFF_FFFC;
      tick();
      j_signal = 1'b0;
      jump     = 32'h0;
      check("t5_out", out, 32'hFFFF_FFFC);
      expect_fetch(32'hFFFF_FFFC);
      expect_fetch(32'h0);
      stall = 1'b0;
      wait_valid("t5_v0");
      wait_valid("t5_v1");
      stall = 1'b1;
      tick();
      check("t5_out_after", out, 32'h4);
      check_drained("t5");

      // 6: stall holds off requests, halt in RESP delivers then stops
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t6_stall_noreq", {31'h0, imem_req}, 32'h0);
      end
      expect_fetch(32'h0);
      stall = 1'b0;
      wait_req("t6_req");
      tick();
      halt = 1'b1;
      wait_valid("t6_v");
      halt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t6_halted_noreq", {31'h0, imem_req}, 32'h0);
         check("t6_halted_novalid", {31'h0, instr_valid}, 32'h0);
      end
      check("t6_halted_out", out, 32'h4);
      check_drained("t6");
      do_reset();
      check_reset_vals("t6");
      expect_fetch(32'h0);
      stall = 1'b0;
      wait_valid("t6_restart");
      stall = 1'b1;
      tick();
      check_drained("t6_restart");

      check("misaligned_pulses", 32'(mis_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
